// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS load/store unit and its Avalon-MM bus interface.
// Holds the operation and FSM state encodings plus small op-decode helpers.
package mips_bus_pkg;

  typedef enum logic [3:0] {
    OP_LB     = 4'd0,
    OP_LBU    = 4'd1,
    OP_LH     = 4'd2,
    OP_LHU    = 4'd3,
    OP_LW     = 4'd4,
    OP_LWL    = 4'd5,
    OP_LWR    = 4'd6,
    OP_SB     = 4'd7,
    OP_SH     = 4'd8,
    OP_SW     = 4'd9,
    OP_IFETCH = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic is_store(lsu_op_t op);
    logic st;
    st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    return st;
  endfunction

  // LWL/LWR and byte accesses are legal at any offset.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
    logic bad;
    case (op)
      OP_LH, OP_LHU, OP_SH:     bad = off[0];
      OP_LW, OP_SW, OP_IFETCH:  bad = (off != 2'b00);
      default:                  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Byte-lane steering: store replication/byteenable and load extract, extend
// and LWL/LWR merge. Purely combinational.
module mips_lsu_align
  import mips_bus_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [31:0] store_data,
  output logic [3:0]  store_be,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] lwl_data;
  logic [31:0] lwr_data;

  always_comb begin
    case (offset)
      2'd0:    lane_byte = readdata[7:0];
      2'd1:    lane_byte = readdata[15:8];
      2'd2:    lane_byte = readdata[23:16];
      default: lane_byte = readdata[31:24];
    endcase
    lane_half = offset[1] ? readdata[31:16] : readdata[15:0];
  end

  // LWL fills the high end of rt from the low memory bytes, LWR the reverse.
  always_comb begin
    case (offset)
      2'd0:    lwl_data = {readdata[7:0],  wdata[23:0]};
      2'd1:    lwl_data = {readdata[15:0], wdata[15:0]};
      2'd2:    lwl_data = {readdata[23:0], wdata[7:0]};
      default: lwl_data = readdata;
    endcase
    case (offset)
      2'd0:    lwr_data = readdata;
      2'd1:    lwr_data = {wdata[31:24], readdata[31:8]};
      2'd2:    lwr_data = {wdata[31:16], readdata[31:16]};
      default: lwr_data = {wdata[31:8],  readdata[31:24]};
    endcase
  end

  always_comb begin
    store_data = 32'h0;
    store_be   = 4'b1111;
    case (op)
      OP_SB: begin
        store_data = {4{wdata[7:0]}};
        store_be   = 4'b0001 << offset;
      end
      OP_SH: begin
        store_data = {2{wdata[15:0]}};
        store_be   = offset[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        store_data = wdata;
        store_be   = 4'b1111;
      end
      default: begin
        store_data = 32'h0;
        store_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (op)
      OP_LB:            load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:           load_data = {24'h0, lane_byte};
      OP_LH:            load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:           load_data = {16'h0, lane_half};
      OP_LW, OP_IFETCH: load_data = readdata;
      OP_LWL:           load_data = lwl_data;
      OP_LWR:           load_data = lwr_data;
      default:          load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// MIPS load/store unit bridging single core requests onto an Avalon-MM
// master port, one transaction at a time, with optional waitrequest timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a request; req_ready high
//   ST_BUS  | strobe held until waitrequest drops or the timeout expires
//   ST_RESP | one-cycle rsp_valid pulse, then back to idle
module mips_bus_lsu
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  lsu_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  lsu_state_t       state;
  lsu_op_t          op_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] wait_cnt;

  lsu_op_t     align_op;
  logic [1:0]  align_off;
  logic [31:0] align_wdata;
  logic [31:0] store_data;
  logic [3:0]  store_be;
  logic [31:0] load_data;

  // Idle: steer the incoming store; otherwise merge against the latched request.
  assign align_op    = (state == ST_IDLE) ? req_op         : op_q;
  assign align_off   = (state == ST_IDLE) ? req_addr[1:0]  : off_q;
  assign align_wdata = (state == ST_IDLE) ? req_wdata      : wdata_q;

  mips_lsu_align u_align (
    .op         (align_op),
    .offset     (align_off),
    .wdata      (align_wdata),
    .readdata   (readdata),
    .store_data (store_data),
    .store_be   (store_be),
    .load_data  (load_data)
  );

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_LW;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      wait_cnt   <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'h0;
      byteenable <= 4'b0000;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= 32'h0;
          if (req_valid) begin
            op_q     <= req_op;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            wait_cnt <= '0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state      <= ST_BUS;
              address    <= {req_addr[ADDR_W-1:2], 2'b00};
              read       <= !is_store(req_op);
              write      <= is_store(req_op);
              byteenable <= store_be;
              writedata  <= store_data;
            end
          end
        end

        ST_BUS: begin
          if (!waitrequest) begin
            state      <= ST_RESP;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_data   <= is_store(op_q) ? 32'h0 : load_data;
          end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LAST)) begin
            state      <= ST_RESP;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_data   <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= 32'h0;
        end

        default: begin
          state <= ST_IDLE;
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed vector bench for mips_bus_lsu with TIMEOUT=4, plus sequences for
// reset during a stalled read and requests arriving while busy.
`timescale 1ns/1ps
module tb_mips_bus_lsu;
  import mips_bus_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;

  int checks = 0;
  int errors = 0;

  mips_bus_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  typedef struct {
    lsu_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_lat;
    int          exp_str;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int str;
    bit got;
    @(negedge clk);
    chk1($sformatf("v%0d req_ready", idx), req_ready, 1'b1);
    req_valid   = 1'b1;
    req_op      = v.op;
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    readdata    = v.rdata;
    waitrequest = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h5A5A5A5A;
    cyc = 1;
    str = 0;
    got = 1'b0;
    while (!got && cyc <= 20) begin
      if (rsp_valid) begin
        got = 1'b1;
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_lat));
        chk($sformatf("v%0d strobe_cycles", idx), 32'(str), 32'(v.exp_str));
        chk($sformatf("v%0d rsp_data", idx), rsp_data, v.exp_data);
        chk1($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        chk1($sformatf("v%0d strobes_low_at_rsp", idx), read | write, 1'b0);
      end else begin
        chk($sformatf("v%0d idle_rsp_data", idx), rsp_data, 32'h0);
        if (read || write) begin
          str++;
          chk1($sformatf("v%0d write", idx), write, v.exp_wr);
          chk1($sformatf("v%0d read", idx), read, !v.exp_wr);
          chk($sformatf("v%0d address", idx), address, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d byteenable", idx), 32'(byteenable), 32'(v.exp_be));
          if (v.exp_wr)
            chk($sformatf("v%0d writedata", idx), writedata, v.exp_wd);
          waitrequest = (str <= v.waits);
        end else begin
          waitrequest = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL v%0d rsp_timeout actual=no_response required=response", idx);
    end
    waitrequest = 1'b0;
    @(negedge clk);
    chk1($sformatf("v%0d rsp_valid_pulse", idx), rsp_valid, 1'b0);
    chk($sformatf("v%0d rsp_data_after", idx), rsp_data, 32'h0);
    chk1($sformatf("v%0d rsp_err_after", idx), rsp_err, 1'b0);
    chk1($sformatf("v%0d ready_after", idx), req_ready, 1'b1);
  endtask

  vec_t vecs[22];

  initial begin
    //            op         addr      wdata         rdata         w   exp_data      err  wr   be       exp_wd        lat str
    vecs[0]  = '{OP_LW,     32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[1]  = '{OP_LB,     32'h103, 32'h0,        32'h80112233, 3, 32'hFFFFFF80, 1'b0, 1'b0, 4'b1111, 32'h0,        5, 4};
    vecs[2]  = '{OP_SH,     32'h202, 32'h0000ABCD, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 2, 1};
    vecs[3]  = '{OP_LWL,    32'h101, 32'hAABBCCDD, 32'h44332211, 0, 32'h2211CCDD, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[4]  = '{OP_LWR,    32'h101, 32'hAABBCCDD, 32'h44332211, 0, 32'hAA443322, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[5]  = '{OP_LW,     32'h102, 32'h0,        32'h12345678, 0, 32'h0,        1'b1, 1'b0, 4'b1111, 32'h0,        1, 0};
    vecs[6]  = '{OP_LW,     32'h300, 32'h0,        32'h12345678, 99, 32'h0,       1'b1, 1'b0, 4'b1111, 32'h0,        5, 4};
    vecs[7]  = '{OP_LBU,    32'h102, 32'h0,        32'h80FF7F01, 0, 32'h000000FF, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[8]  = '{OP_LH,     32'h102, 32'h0,        32'h80011234, 0, 32'hFFFF8001, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[9]  = '{OP_LHU,    32'h100, 32'h0,        32'h8001F234, 0, 32'h0000F234, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[10] = '{OP_SB,     32'h101, 32'h123456A5, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'b0010, 32'hA5A5A5A5, 2, 1};
    vecs[11] = '{OP_SW,     32'h104, 32'hCAFEF00D, 32'h0,        2, 32'h0,        1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, 4, 3};
    vecs[12] = '{OP_IFETCH, 32'h108, 32'h0,        32'h24080001, 1, 32'h24080001, 1'b0, 1'b0, 4'b1111, 32'h0,        3, 2};
    vecs[13] = '{OP_LH,     32'h101, 32'h0,        32'h0,        0, 32'h0,        1'b1, 1'b0, 4'b1111, 32'h0,        1, 0};
    vecs[14] = '{OP_SH,     32'h203, 32'h0000BEEF, 32'h0,        0, 32'h0,        1'b1, 1'b1, 4'b1111, 32'h0,        1, 0};
    vecs[15] = '{OP_IFETCH, 32'h10A, 32'h0,        32'h0,        0, 32'h0,        1'b1, 1'b0, 4'b1111, 32'h0,        1, 0};
    vecs[16] = '{OP_LWL,    32'h103, 32'hAABBCCDD, 32'h44332211, 0, 32'h44332211, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[17] = '{OP_LWR,    32'h100, 32'hAABBCCDD, 32'h44332211, 0, 32'h44332211, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[18] = '{OP_LWL,    32'h100, 32'hAABBCCDD, 32'h44332211, 0, 32'h11BBCCDD, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[19] = '{OP_LWR,    32'h103, 32'hAABBCCDD, 32'h44332211, 0, 32'hAABBCC44, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[20] = '{OP_LB,     32'h100, 32'h0,        32'h0000007F, 0, 32'h0000007F, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1};
    vecs[21] = '{OP_SH,     32'h200, 32'h9999ABCD, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'b0011, 32'hABCDABCD, 2, 1};

    reset       = 1'b0;
    req_valid   = 1'b0;
    req_op      = OP_LW;
    req_addr    = '0;
    req_wdata   = 32'h0;
    waitrequest = 1'b0;
    readdata    = 32'h0;
    #1;
    chk1("reset read", read, 1'b0);
    chk1("reset write", write, 1'b0);
    chk("reset byteenable", 32'(byteenable), 32'h0);
    chk("reset address", address, 32'h0);
    chk("reset writedata", writedata, 32'h0);
    chk1("reset rsp_valid", rsp_valid, 1'b0);
    chk1("reset rsp_err", rsp_err, 1'b0);
    chk("reset rsp_data", rsp_data, 32'h0);
    chk1("reset req_ready", req_ready, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

    // A second request held high during a stalled read must not disturb it.
    @(negedge clk);
    req_valid   = 1'b1;
    req_op      = OP_LW;
    req_addr    = 32'h140;
    readdata    = 32'h13579BDF;
    waitrequest = 1'b1;
    @(negedge clk);
    req_op    = OP_SW;
    req_addr  = 32'h3F0;
    req_wdata = 32'hFFFFFFFF;
    chk1("busy req_ready", req_ready, 1'b0);
    chk1("busy read", read, 1'b1);
    chk("busy address", address, 32'h140);
    @(negedge clk);
    chk("busy address_held", address, 32'h140);
    chk1("busy no_write", write, 1'b0);
    waitrequest = 1'b0;
    @(negedge clk);
    chk1("busy rsp_valid", rsp_valid, 1'b1);
    chk("busy rsp_data", rsp_data, 32'h13579BDF);
    chk1("busy resp_not_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("busy rsp_done", rsp_valid, 1'b0);
    chk1("busy no_strobe", read | write, 1'b0);

    // Reset while a read is stalled: abandoned with no response.
    @(negedge clk);
    req_valid   = 1'b1;
    req_op      = OP_LW;
    req_addr    = 32'h180;
    waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("rstbus read_before", read, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk1("rstbus read_async", read, 1'b0);
    chk1("rstbus rsp_valid", rsp_valid, 1'b0);
    chk("rstbus address", address, 32'h0);
    chk("rstbus byteenable", 32'(byteenable), 32'h0);
    chk1("rstbus req_ready", req_ready, 1'b1);
    @(negedge clk);
    reset       = 1'b1;
    waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1($sformatf("rstbus quiet%0d rsp_valid", i), rsp_valid, 1'b0);
      chk1($sformatf("rstbus quiet%0d read", i), read, 1'b0);
    end
    run_vec('{OP_LW, 32'h180, 32'h0, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 1'b0, 4'b1111, 32'h0, 2, 1}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
